// File: rtl/sdram_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sdram_responder_if : SDRAM command/address strobes plus responder status     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface sdram_responder_if;
  logic [12:0] addr;
  logic [1:0]  bank_addr;
  logic        clock_enable;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic        data_mask_low;
  logic        data_mask_high;
  logic        ready;
  logic        err;
  logic [2:0]  err_code;

  modport master (
    output addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
           data_mask_low, data_mask_high,
    input  ready, err, err_code
  );

  modport slave (
    input  addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
           data_mask_low, data_mask_high,
    output ready, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/sdram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sdram_responder : cycle-accurate SDRAM device model with protocol checking.  |
// | Optional: SDRAM_TIMING_CHECK_EN adds per-bank tRCD/tRP checks (code 7).      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sdram_responder #(
  parameter int ROW_BITS       = 3,
  parameter int COL_BITS       = 5,
  parameter int INIT_REFRESHES = 2,
  parameter int T_RCD          = 2,
  parameter int T_RP           = 2
) (
  input  wire               clk,
  input  wire               rst,
  sdram_responder_if.slave  bus,
  inout  wire  [15:0]       data
);

  localparam int c_IDX_W = 2 + ROW_BITS + COL_BITS;
  localparam int c_DEPTH = 1 << c_IDX_W;

  localparam logic [1:0] S_WAIT_PRE = 2'd0;
  localparam logic [1:0] S_REFRESH  = 2'd1;
  localparam logic [1:0] S_MODE     = 2'd2;
  localparam logic [1:0] S_READY    = 2'd3;

  localparam logic [3:0] c_CMD_ACT = 4'b0011;
  localparam logic [3:0] c_CMD_RD  = 4'b0101;
  localparam logic [3:0] c_CMD_WR  = 4'b0100;
  localparam logic [3:0] c_CMD_PRE = 4'b0010;
  localparam logic [3:0] c_CMD_REF = 4'b0001;
  localparam logic [3:0] c_CMD_LMR = 4'b0000;

  localparam logic [7:0] c_REF_LAST = 8'(INIT_REFRESHES - 1);

  // ---------------------------------------------------------------- decode
  logic [3:0] w_cmd;
  logic       w_en;
  logic       w_act, w_rd, w_wr, w_pre, w_ref, w_lmr;
  logic [1:0] w_bank;
  logic       w_bank_open;
  logic       w_ready;
  logic [2:0] w_cl_new;
  logic       w_cl_legal;
  logic       w_rd_ok, w_wr_ok, w_act_ok;
  logic       w_unused;

  assign w_cmd       = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};
  assign w_en        = bus.clock_enable;
  assign w_act       = w_en && (w_cmd == c_CMD_ACT);
  assign w_rd        = w_en && (w_cmd == c_CMD_RD);
  assign w_wr        = w_en && (w_cmd == c_CMD_WR);
  assign w_pre       = w_en && (w_cmd == c_CMD_PRE);
  assign w_ref       = w_en && (w_cmd == c_CMD_REF);
  assign w_lmr       = w_en && (w_cmd == c_CMD_LMR);
  assign w_bank      = bus.bank_addr;
  assign w_cl_new    = bus.addr[6:4];
  assign w_cl_legal  = (w_cl_new == 3'd2) || (w_cl_new == 3'd3);
  assign w_unused    = ^bus.addr;

  // ---------------------------------------------------------------- init FSM
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_ref_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_WAIT_PRE;
      r_ref_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_REFRESH) && w_ref) begin
        r_ref_cnt <= r_ref_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_PRE: if (w_pre && bus.addr[10])                w_state_nxt = S_REFRESH;
      S_REFRESH:  if (w_ref && (r_ref_cnt == c_REF_LAST))   w_state_nxt = S_MODE;
      S_MODE:     if (w_lmr)                                w_state_nxt = S_READY;
      default:                                              w_state_nxt = S_READY;
    endcase
  end

  always_comb begin
    w_ready = (r_state == S_READY);
  end

  assign bus.ready = w_ready;

  // ---------------------------------------------------------------- banks / mode
  logic [3:0]          r_open;
  logic [ROW_BITS-1:0] r_row [4];
  logic [2:0]          r_cl;

  assign w_bank_open = r_open[w_bank];
  assign w_rd_ok     = w_rd  && w_ready && w_bank_open;
  assign w_wr_ok     = w_wr  && w_ready && w_bank_open;
  assign w_act_ok    = w_act && w_ready && !w_bank_open;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_open <= 4'b0000;
      r_cl   <= 3'd3;
    end else begin
      if (w_act_ok) begin
        r_open[w_bank] <= 1'b1;
        r_row[w_bank]  <= bus.addr[ROW_BITS-1:0];
      end
      if (w_pre) begin
        if (bus.addr[10]) r_open         <= 4'b0000;
        else              r_open[w_bank] <= 1'b0;
      end
      if (w_lmr && w_cl_legal) begin
        r_cl <= w_cl_new;
      end
    end
  end

  // ---------------------------------------------------------------- storage
  logic [15:0]        r_mem [c_DEPTH];
  logic [c_IDX_W-1:0] w_idx;
  logic [15:0]        w_old;
  logic [15:0]        w_wr_word;

  assign w_idx     = {w_bank, r_row[w_bank], bus.addr[COL_BITS-1:0]};
  assign w_old     = r_mem[w_idx];
  assign w_wr_word = {bus.data_mask_high ? w_old[15:8] : data[15:8],
                      bus.data_mask_low  ? w_old[7:0]  : data[7:0]};

  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  // ---------------------------------------------------------------- read pipeline
  // Stage k holds a read k+1 edges old; the output flop then adds the last cycle.
  logic [2:0]  r_rd_v;
  logic [15:0] r_rd_d [3];
  logic        r_oe;
  logic [15:0] r_dq;
  logic        w_tap_v;
  logic [15:0] w_tap_d;

  assign w_tap_v = (r_cl == 3'd2) ? r_rd_v[1] : r_rd_v[2];
  assign w_tap_d = (r_cl == 3'd2) ? r_rd_d[1] : r_rd_d[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_v <= 3'b000;
      r_oe   <= 1'b0;
    end else if (w_en) begin
      r_rd_v <= {r_rd_v[1:0], w_rd_ok};
      r_oe   <= w_tap_v;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_rd_d[0] <= w_old;
      r_rd_d[1] <= r_rd_d[0];
      r_rd_d[2] <= r_rd_d[1];
      r_dq      <= w_tap_d;
    end
  end

  assign data = r_oe ? r_dq : 16'hzzzz;

  // ---------------------------------------------------------------- timing checks
  logic w_tviol;

`ifdef SDRAM_TIMING_CHECK_EN
  localparam logic [7:0] c_RCD_LOAD = (T_RCD > 0) ? 8'(T_RCD - 1) : 8'd0;
  localparam logic [7:0] c_RP_LOAD  = (T_RP  > 0) ? 8'(T_RP  - 1) : 8'd0;

  logic [7:0] r_rcd_cnt [4];
  logic [7:0] r_rp_cnt  [4];

  assign w_tviol = ((w_rd || w_wr) && w_ready && w_bank_open && (r_rcd_cnt[w_bank] != 8'd0))
                || (w_act_ok && (r_rp_cnt[w_bank] != 8'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_rcd_cnt[i] <= 8'd0;
        r_rp_cnt[i]  <= 8'd0;
      end
    end else if (w_en) begin
      for (int i = 0; i < 4; i++) begin
        if (r_rcd_cnt[i] != 8'd0) r_rcd_cnt[i] <= r_rcd_cnt[i] - 8'd1;
        if (r_rp_cnt[i]  != 8'd0) r_rp_cnt[i]  <= r_rp_cnt[i]  - 8'd1;
        if (w_act_ok && (w_bank == 2'(i)))                   r_rcd_cnt[i] <= c_RCD_LOAD;
        if (w_pre && (bus.addr[10] || (w_bank == 2'(i))))    r_rp_cnt[i]  <= c_RP_LOAD;
      end
    end
  end
`else
  localparam int c_TIMING_UNUSED = T_RCD + T_RP;
  assign w_tviol = 1'b0;
`endif

  // ---------------------------------------------------------------- error capture
  logic       w_viol;
  logic [2:0] w_viol_code;
  logic       r_err;
  logic [2:0] r_err_code;

  always_comb begin
    w_viol      = 1'b0;
    w_viol_code = 3'd0;
    if ((w_act || w_rd || w_wr) && !w_ready) begin
      w_viol = 1'b1; w_viol_code = 3'd1;
    end else if (w_lmr && !w_cl_legal) begin
      w_viol = 1'b1; w_viol_code = 3'd2;
    end else if (w_act && w_bank_open) begin
      w_viol = 1'b1; w_viol_code = 3'd3;
    end else if (w_ref && w_ready && (r_open != 4'b0000)) begin
      w_viol = 1'b1; w_viol_code = 3'd4;
    end else if ((w_rd || w_wr) && !w_bank_open) begin
      w_viol = 1'b1; w_viol_code = 3'd5;
    end else if (w_wr && r_oe) begin
      w_viol = 1'b1; w_viol_code = 3'd6;
    end else if (w_tviol) begin
      w_viol = 1'b1; w_viol_code = 3'd7;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
    end else if (w_viol && !r_err) begin
      r_err      <= 1'b1;
      r_err_code <= w_viol_code;
    end
  end

  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_sdram_responder : directed bench for sdram_responder                      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_sdram_responder;

  localparam logic [3:0] c_NOP = 4'b0111;
  localparam logic [3:0] c_ACT = 4'b0011;
  localparam logic [3:0] c_RD  = 4'b0101;
  localparam logic [3:0] c_WR  = 4'b0100;
  localparam logic [3:0] c_PRE = 4'b0010;
  localparam logic [3:0] c_REF = 4'b0001;
  localparam logic [3:0] c_LMR = 4'b0000;
  localparam logic [15:0] c_HIZ = 16'hffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tb_dq = 16'h0000;
  logic        tb_oe = 1'b0;
  tri1  [15:0] data;
  int          n_checks = 0;
  int          n_errors = 0;

  sdram_responder_if bus ();

  assign data = tb_oe ? tb_dq : 16'hzzzz;

  sdram_responder #(
    .ROW_BITS       (3),
    .COL_BITS       (5),
    .INIT_REFRESHES (2),
    .T_RCD          (2),
    .T_RP           (2)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    bus.cs_n      = c[3];
    bus.ras_n     = c[2];
    bus.cas_n     = c[1];
    bus.we_n      = c[0];
    bus.bank_addr = b;
    bus.addr      = a;
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    set_cmd(c, b, a);
    @(posedge clk);
    #1;
    set_cmd(c_NOP, 2'd0, 13'd0);
  endtask

  task automatic write(input logic [1:0] b, input logic [8:0] col, input logic [15:0] d,
                       input logic mh, input logic ml);
    tb_dq              = d;
    tb_oe              = 1'b1;
    bus.data_mask_high = mh;
    bus.data_mask_low  = ml;
    issue(c_WR, b, {4'd0, col});
    tb_oe              = 1'b0;
    bus.data_mask_high = 1'b0;
    bus.data_mask_low  = 1'b0;
  endtask

  // k counts edges after the READ edge; data is expected only in the cycle after edge cl.
  task automatic read_check(input logic [1:0] b, input logic [8:0] col, input int cl,
                            input logic [15:0] exp, input string tag);
    issue(c_RD, b, {4'd0, col});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("%s_k%0d", tag, k), {16'd0, data}, {16'd0, (k == cl) ? exp : c_HIZ});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_init(input logic [12:0] mode, input string tag);
    issue(c_PRE, 2'd0, 13'h0400);
    issue(c_REF, 2'd0, 13'd0);
    issue(c_REF, 2'd0, 13'd0);
    @(negedge clk);
    check({tag, "_ready_pre"}, {31'd0, bus.ready}, 32'd0);
    issue(c_LMR, 2'd0, mode);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
  endtask

  initial begin
    bus.clock_enable   = 1'b1;
    bus.data_mask_low  = 1'b0;
    bus.data_mask_high = 1'b0;
    set_cmd(c_NOP, 2'd0, 13'd0);

    do_reset();
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_code", {29'd0, bus.err_code}, 32'd0);
    check("rst_data", {16'd0, data}, {16'd0, c_HIZ});

    // Init, write/read at CL=3, byte masks
    do_init(13'h030, "init");
    issue(c_ACT, 2'd3, 13'h1fb6);
    issue(c_NOP, 2'd0, 13'd0);
    issue(c_NOP, 2'd0, 13'd0);
    write(2'd3, 9'h1ed, 16'd3333, 1'b0, 1'b0);
    read_check(2'd3, 9'h1ed, 3, 16'd3333, "rd_cl3");
    write(2'd3, 9'h002, 16'hbbbb, 1'b0, 1'b0);
    write(2'd3, 9'h002, 16'h1234, 1'b1, 1'b0);
    read_check(2'd3, 9'h002, 3, 16'hbb34, "mask_hi");
    write(2'd3, 9'h002, 16'h5678, 1'b0, 1'b1);
    read_check(2'd3, 9'h002, 3, 16'h5634, "mask_lo");

    // CAS latency 2, then an illegal mode keeps it
    issue(c_LMR, 2'd0, 13'h020);
    read_check(2'd3, 9'h1ed, 2, 16'd3333, "rd_cl2");
    check("cl2_err", {31'd0, bus.err}, 32'd0);
    issue(c_LMR, 2'd0, 13'h050);
    @(negedge clk);
    check("badcl_err", {31'd0, bus.err}, 32'd1);
    check("badcl_code", {29'd0, bus.err_code}, 32'd2);
    read_check(2'd3, 9'h1ed, 2, 16'd3333, "cl_kept");

    // Command before init completes
    do_reset();
    check("rst2_err", {31'd0, bus.err}, 32'd0);
    check("rst2_code", {29'd0, bus.err_code}, 32'd0);
    issue(c_ACT, 2'd0, 13'd0);
    @(negedge clk);
    check("early_err", {31'd0, bus.err}, 32'd1);
    check("early_code", {29'd0, bus.err_code}, 32'd1);

    // Reset while a read is in flight
    do_reset();
    do_init(13'h030, "init2");
    issue(c_ACT, 2'd3, 13'h1fb6);
    issue(c_NOP, 2'd0, 13'd0);
    issue(c_NOP, 2'd0, 13'd0);
    issue(c_RD, 2'd3, 13'h01ed);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rst_rd_k%0d", k), {16'd0, data}, {16'd0, c_HIZ});
    end
    rst = 1'b0;
    check("rst_rd_ready", {31'd0, bus.ready}, 32'd0);

    // Bank closed by reset: closed-bank access errors, storage survives
    do_init(13'h030, "init3");
    read_check(2'd3, 9'h1ed, -1, 16'h0000, "closed3");
    check("closed_err", {31'd0, bus.err}, 32'd1);
    check("closed_code", {29'd0, bus.err_code}, 32'd5);
    read_check(2'd1, 9'h000, -1, 16'h0000, "closed1");
    issue(c_ACT, 2'd0, 13'd0);
    issue(c_ACT, 2'd0, 13'd0);
    @(negedge clk);
    check("sticky_err", {31'd0, bus.err}, 32'd1);
    check("sticky_code", {29'd0, bus.err_code}, 32'd5);
    issue(c_ACT, 2'd3, 13'h1fb6);
    issue(c_NOP, 2'd0, 13'd0);
    issue(c_NOP, 2'd0, 13'd0);
    read_check(2'd3, 9'h1ed, 3, 16'd3333, "persist");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Cycle-accurate SDRAM device responder: the memory end of the SDRAM command interface driven by sdram_controller.
- Decodes cs_n/ras_n/cas_n/we_n commands, tracks the init sequence and per-bank open rows, stores write data, and returns read data after the programmed CAS latency.
- Flags protocol violations so controller benches can close the loop without an external vendor model.

Parameters:
- ROW_BITS, 3: low row-address bits used in the storage index.
- COL_BITS, 5: low column-address bits used in the storage index.
- INIT_REFRESHES, 2: AUTO REFRESH commands required during init.
- T_RCD, 2: minimum cycles from ACTIVE to READ/WRITE on the same bank (timing check only).
- T_RP, 2: minimum cycles from PRECHARGE to ACTIVE on the same bank (timing check only).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- addr  in  13  row (ACTIVE), column [8:0] (READ/WRITE), A10 all-bank flag (PRECHARGE), mode (LOAD MODE).
- bank_addr  in  2  bank select.
- data  inout  16  data bus; driven only during read-data cycles, else high-Z.
- clock_enable  in  1  CKE; low freezes all state.
- cs_n, ras_n, cas_n, we_n  in  1 each  command strobes.
- data_mask_low, data_mask_high  in  1 each  write byte masks; 1 = byte not written.
- ready  out  1  init sequence complete.
- err  out  1  sticky protocol-violation flag.
- err_code  out  3  code of the first violation.

Behaviour:
- Reset: ready=0, err=0, err_code=0, all banks closed, read pipeline empty, data high-Z, CAS latency=3, init FSM=WAIT_PRE. Storage contents are not cleared. Reset mid-read drops pending data on the next cycle.
- Command decode ({cs_n,ras_n,cas_n,we_n}):
  - 1xxx DESELECT, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO REFRESH, 0000 LOAD MODE.
  - clock_enable=0: command ignored; read pipeline and timers hold.
- Init FSM:
  - WAIT_PRE → REFRESH on PRECHARGE with addr[10]=1.
  - REFRESH counts AUTO REFRESH commands; after INIT_REFRESHES of them → MODE.
  - MODE → READY on LOAD MODE; ready=1 from the next cycle.
  - Any ACTIVE/READ/WRITE before READY: err_code=1, command ignored.
- LOAD MODE: CAS latency = addr[6:4]. Legal values are 2 and 3; any other value gives err_code=2 and keeps the previous latency. Burst length is fixed at 1.
- ACTIVE: opens bank_addr and latches the row. ACTIVE to an already-open bank gives err_code=3; the row is not changed.
- PRECHARGE: addr[10]=1 closes all banks, else only bank_addr. Precharging a closed bank is legal.
- AUTO REFRESH in READY with any bank open: err_code=4.
- Storage index = {bank_addr, open_row[ROW_BITS-1:0], addr[COL_BITS-1:0]}; depth 2^(2+ROW_BITS+COL_BITS) words of 16 bits.
- WRITE to an open bank:
  - data sampled in the command cycle.
  - Low byte written unless data_mask_low=1; high byte written unless data_mask_high=1.
- READ to an open bank:
  - Word captured at the command cycle and pushed into a 3-stage valid/data pipeline.
  - Driven on data for exactly one cycle, starting CL cycles after the READ edge.
  - Back-to-back READs give back-to-back data.
- READ/WRITE to a closed bank: err_code=5, no access.
- WRITE issued in a cycle where the responder is driving data (bus conflict): err_code=6; the write still occurs.
- Error reporting: err sets on the first violation and is sticky until rst. err_code holds the first violation's code. Same-cycle ties are impossible because there is one command per cycle.

Optional Feature:
- SDRAM_TIMING_CHECK_EN defined:
  - Per-bank counters enforce T_RCD (ACTIVE → READ/WRITE) and T_RP (PRECHARGE → ACTIVE).
  - Violation gives err_code=7; the command still executes.
- Not defined: no timing counters, no code 7.

Test Plan:
- Init sequence: PRECHARGE A10=1, 2× AUTO REFRESH, LOAD MODE addr=13'h030 → ready=1 one cycle after LOAD MODE, err=0.
- Write then read: ACTIVE bank 3 row 13'h1fb6, WRITE col 9'h1ed data 16'd3333, READ same col → data=16'd3333 exactly 3 cycles after READ, high-Z otherwise.
- Byte masks: WRITE 16'hbbbb, then WRITE 16'h1234 with data_mask_high=1 → subsequent READ returns 16'hbb34.
- CL=2: LOAD MODE addr=13'h020 → read data appears 2 cycles after READ; LOAD MODE addr=13'h050 → err=1, err_code=2, CL stays 2.
- Violations: READ to closed bank 1 → err=1, err_code=5, data stays high-Z; a further ACTIVE before rst leaves err_code=5.
- Reset with a read pending: READ, then rst asserted the next cycle → data never driven, ready=0, bank closed.
